// File: rtl/looper_pkg.sv
// ============================================================================
// Module   : looper_pkg
// Purpose  : Shared types and constants for the looper RAM interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package looper_pkg;

  localparam int RAM_DW = 32;
  localparam int RAM_AW = 27;
  localparam logic [RAM_DW-1:0] RAM_INIT_VAL = 32'h7FFF_FFFF;

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_RD   = 2'd1,
    OP_WR   = 2'd2
  } ram_op_e;

  // Expands active-high {upper, lower} lane enables into a 32-bit data mask.
  function automatic logic [RAM_DW-1:0] lane_mask(input logic [1:0] lanes);
    return {{16{lanes[1]}}, {16{lanes[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_bram_bytewe.sv
// ============================================================================
// Module   : ram_bram_bytewe
// Purpose  : Single-port 32-bit block RAM, two 16-bit write lanes, registered read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_bram_bytewe
  import looper_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [1:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [RAM_DW-1:0] i_din,
  output logic [RAM_DW-1:0] o_dout
);

  logic [RAM_DW-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [RAM_DW-1:0] r_dout;

  always_ff @(posedge clk) begin
    if (i_we[0]) r_mem[i_addr][15:0]  <= i_din[15:0];
    if (i_we[1]) r_mem[i_addr][31:16] <= i_din[31:16];
    if (i_en)    r_dout <= r_mem[i_addr];
  end

  assign o_dout = r_dout;

endmodule

`default_nettype wire

// File: rtl/ram_sram_responder.sv
// ============================================================================
// Module   : ram_sram_responder
// Purpose  : Async-SRAM-style responder on block RAM with programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sram_responder
  import looper_pkg::*;
#(
  parameter int                ADDR_W   = 14,
  parameter int                RD_LAT   = 8,
  parameter int                WR_LAT   = 6,
  parameter logic [RAM_DW-1:0] INIT_VAL = RAM_INIT_VAL
) (
  input  logic              clk_100MHz,
  input  logic              rstn,
  input  logic [RAM_AW-1:0] ram_a,
  input  logic [RAM_DW-1:0] ram_dq_i,
  output logic [RAM_DW-1:0] ram_dq_o,
  input  logic              ram_cen,
  input  logic              ram_oen,
  input  logic              ram_wen,
  input  logic              ram_ub,
  input  logic              ram_lb,
  input  logic              mem_clr,
  output logic              busy,
  output logic              ack,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_WAIT = 3'd1,
    S_WR_WAIT = 3'd2,
    S_DONE    = 3'd3,
    S_CLR     = 3'd4
  } state_e;

  localparam int                  C_MAX_LAT  = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int                  C_CNT_W    = $clog2(C_MAX_LAT + 1);
  localparam logic [C_CNT_W-1:0]  C_RD_LAST  = C_CNT_W'(RD_LAT - 2);
  localparam logic [C_CNT_W-1:0]  C_WR_LAST  = C_CNT_W'((WR_LAT >= 2) ? WR_LAT - 2 : 0);
  localparam logic [ADDR_W-1:0]   C_CLR_LAST = '1;

  state_e              r_state, w_state_nxt;
  logic [C_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_clr_addr, w_clr_addr_nxt;
  logic                r_cen_q;
  ram_op_e             r_op, w_dec_op;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_oor;
  logic [RAM_DW-1:0]   r_data;
  logic [1:0]          r_lanes;
  logic                r_err;
  logic [RAM_DW-1:0]   r_dq_hold;

  logic                w_cen_fall, w_oor, w_accept, w_clr_start;
  logic                w_wr_slot, w_rd_done, w_bram_en;
  logic [1:0]          w_bram_we;
  logic [ADDR_W-1:0]   w_bram_addr;
  logic [RAM_DW-1:0]   w_bram_din, w_bram_dout, w_rd_data;

  assign w_cen_fall  = r_cen_q & ~ram_cen;
  assign w_oor       = |ram_a[RAM_AW-1:ADDR_W];
  assign w_dec_op    = !ram_wen ? OP_WR : (!ram_oen ? OP_RD : OP_NONE);
  assign w_accept    = (r_state == S_IDLE) && w_cen_fall && (w_dec_op != OP_NONE);
  // A cen edge always takes priority over a coincident clear request.
  assign w_clr_start = (r_state == S_IDLE) && mem_clr && !w_cen_fall;

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_clr_addr_nxt = r_clr_addr;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt      = '0;
        w_clr_addr_nxt = '0;
        if (w_accept) begin
          if (w_dec_op == OP_RD) w_state_nxt = S_RD_WAIT;
          else                   w_state_nxt = (WR_LAT == 1) ? S_DONE : S_WR_WAIT;
        end else if (w_clr_start) begin
          w_state_nxt = S_CLR;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == C_RD_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_W'(1);
        end
      end
      S_WR_WAIT: begin
        if (r_cnt == C_WR_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_CNT_W'(1);
        end
      end
      S_CLR: begin
        w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        if (r_clr_addr == C_CLR_LAST) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge rstn) begin
    if (!rstn) begin
      r_cen_q   <= 1'b0;
      r_op      <= OP_NONE;
      r_addr    <= '0;
      r_oor     <= 1'b0;
      r_data    <= '0;
      r_lanes   <= 2'b00;
      r_err     <= 1'b0;
      r_dq_hold <= '0;
    end else begin
      r_cen_q <= ram_cen;
      if (w_accept) begin
        r_op    <= w_dec_op;
        r_addr  <= ram_a[ADDR_W-1:0];
        r_oor   <= w_oor;
        r_data  <= ram_dq_i;
        r_lanes <= {~ram_ub, ~ram_lb};
      end else if (w_clr_start) begin
        r_op <= OP_NONE;
      end
      if (w_accept && (w_oor || (!ram_oen && !ram_wen))) r_err <= 1'b1;
      if (w_rd_done) r_dq_hold <= w_rd_data;
    end
  end

  // With WR_LAT=1 there are no wait cycles, so the commit lands in DONE.
  assign w_wr_slot = (WR_LAT == 1) ? (r_state == S_DONE)
                                   : ((r_state == S_WR_WAIT) && (r_cnt == C_WR_LAST));
  assign w_bram_en = (r_state == S_RD_WAIT) && (r_cnt == '0);

  always_comb begin
    w_bram_addr = r_addr;
    w_bram_din  = r_data;
    w_bram_we   = 2'b00;
    if (r_state == S_CLR) begin
      w_bram_addr = r_clr_addr;
      w_bram_din  = INIT_VAL;
      w_bram_we   = 2'b11;
    end else if (w_wr_slot && (r_op == OP_WR) && !r_oor) begin
      w_bram_we = r_lanes;
    end
  end

  ram_bram_bytewe #(
    .ADDR_W (ADDR_W)
  ) u_bram (
    .clk    (clk_100MHz),
    .i_en   (w_bram_en),
    .i_we   (w_bram_we),
    .i_addr (w_bram_addr),
    .i_din  (w_bram_din),
    .o_dout (w_bram_dout)
  );

  assign w_rd_done = (r_state == S_DONE) && (r_op == OP_RD);
  assign w_rd_data = r_oor ? '0 : (w_bram_dout & lane_mask(r_lanes));

  assign ram_dq_o = w_rd_done ? w_rd_data : r_dq_hold;
  assign busy     = (r_state != S_IDLE);
  assign ack      = (r_state == S_DONE);
  assign err      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_sram_responder.sv
// ============================================================================
// Module   : tb_ram_sram_responder
// Purpose  : Directed self-checking bench for ram_sram_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_sram_responder;

  localparam int ADDR_W = 14;
  localparam int RD_LAT = 8;
  localparam int WR_LAT = 6;

  logic        clk_100MHz = 1'b0;
  logic        rstn;
  logic [26:0] ram_a;
  logic [31:0] ram_dq_i;
  logic [31:0] ram_dq_o;
  logic        ram_cen, ram_oen, ram_wen, ram_ub, ram_lb, mem_clr;
  logic        busy, ack, err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  ram_sram_responder #(
    .ADDR_W   (ADDR_W),
    .RD_LAT   (RD_LAT),
    .WR_LAT   (WR_LAT),
    .INIT_VAL (32'h7FFF_FFFF)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .rstn       (rstn),
    .ram_a      (ram_a),
    .ram_dq_i   (ram_dq_i),
    .ram_dq_o   (ram_dq_o),
    .ram_cen    (ram_cen),
    .ram_oen    (ram_oen),
    .ram_wen    (ram_wen),
    .ram_ub     (ram_ub),
    .ram_lb     (ram_lb),
    .mem_clr    (mem_clr),
    .busy       (busy),
    .ack        (ack),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one cen transaction; returns edges-to-ack (-1 on timeout) and data at ack.
  task automatic txn(input logic [26:0] a, input logic [31:0] d, input logic oen,
                     input logic wen, input logic ub, input logic lb, input int hold,
                     output int lat, output logic [31:0] dq);
    @(negedge clk_100MHz);
    ram_a = a; ram_dq_i = d; ram_oen = oen; ram_wen = wen;
    ram_ub = ub; ram_lb = lb; ram_cen = 1'b0;
    lat = -1;
    dq  = 32'hxxxx_xxxx;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk_100MHz); #1;
      if (ack) begin
        lat = n;
        dq  = ram_dq_o;
        break;
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk_100MHz); #1;
      chk("no_second_ack", {31'd0, ack}, 32'd0);
    end
    @(negedge clk_100MHz);
    ram_cen = 1'b1; ram_oen = 1'b1; ram_wen = 1'b1;
    @(negedge clk_100MHz);
  endtask

  int          lat;
  logic [31:0] dq;
  int          busy_cnt;
  int          ack_at;

  initial begin
    rstn = 1'b0; ram_a = '0; ram_dq_i = '0; ram_cen = 1'b1; ram_oen = 1'b1;
    ram_wen = 1'b1; ram_ub = 1'b0; ram_lb = 1'b0; mem_clr = 1'b0;
    #1;
    chk("rst_dq",   ram_dq_o, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack",  {31'd0, ack},  32'd0);
    chk("rst_err",  {31'd0, err},  32'd0);
    @(negedge clk_100MHz); @(negedge clk_100MHz);
    rstn = 1'b1;
    @(negedge clk_100MHz); @(negedge clk_100MHz);

    // Full-word write then read
    txn(27'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 0, lat, dq);
    chk("wr_lat", lat, WR_LAT);
    chk("wr_err", {31'd0, err}, 32'd0);
    txn(27'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, dq);
    chk("rd_lat", lat, RD_LAT);
    chk("rd_data", dq, 32'hDEAD_BEEF);

    // Lower-lane write, full read, upper-lane read
    txn(27'h10, 32'h1111_2222, 1'b1, 1'b0, 1'b1, 1'b0, 0, lat, dq);
    chk("wr_lo_lat", lat, WR_LAT);
    chk("dq_held_after_wr", ram_dq_o, 32'hDEAD_BEEF);
    txn(27'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, dq);
    chk("rd_after_lo_wr", dq, 32'hDEAD_2222);
    txn(27'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 0, lat, dq);
    chk("rd_hi_lane", dq, 32'hDEAD_0000);
    chk("dq_held_idle", ram_dq_o, 32'hDEAD_0000);

    // Out-of-range write must not alias onto address 0
    txn(27'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 1'b0, 0, lat, dq);
    txn(27'h4000, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 1'b0, 0, lat, dq);
    chk("oor_wr_lat", lat, WR_LAT);
    chk("oor_err", {31'd0, err}, 32'd1);
    txn(27'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, dq);
    chk("addr0_unchanged", dq, 32'hCAFE_F00D);
    txn(27'h4000, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, dq);
    chk("oor_rd_lat", lat, RD_LAT);
    chk("oor_rd_data", dq, 32'd0);

    // oen and wen both low: write wins; cen held after ack gives no re-trigger
    txn(27'h30, 32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 1'b0, 3, lat, dq);
    chk("both_low_lat", lat, WR_LAT);
    chk("both_low_err", {31'd0, err}, 32'd1);
    txn(27'h30, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, dq);
    chk("both_low_rd", dq, 32'hA5A5_A5A5);

    // Neither oen nor wen low: no-op
    @(negedge clk_100MHz);
    ram_cen = 1'b0;
    @(posedge clk_100MHz); #1;
    chk("noop_busy", {31'd0, busy}, 32'd0);
    @(posedge clk_100MHz); #1;
    chk("noop_ack", {31'd0, ack}, 32'd0);
    @(negedge clk_100MHz);
    ram_cen = 1'b1;
    @(negedge clk_100MHz);

    // Array clear
    @(negedge clk_100MHz);
    mem_clr = 1'b1;
    @(negedge clk_100MHz);
    mem_clr = 1'b0;
    chk("clr_busy_start", {31'd0, busy}, 32'd1);
    busy_cnt = 1;
    ack_at   = -1;
    for (int n = 0; n < 20000; n++) begin
      @(posedge clk_100MHz); #1;
      if (!busy) break;
      busy_cnt++;
      if (ack) ack_at = busy_cnt;
    end
    chk("clr_busy_cycles", busy_cnt, (1 << ADDR_W) + 1);
    chk("clr_ack_at", ack_at, (1 << ADDR_W) + 1);
    @(negedge clk_100MHz);
    txn(27'h3FFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, dq);
    chk("clr_last_addr", dq, 32'h7FFF_FFFF);
    txn(27'h10, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, dq);
    chk("clr_addr_10", dq, 32'h7FFF_FFFF);

    // Reset during WR_WAIT: write must not commit
    txn(27'h20, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b0, 1'b0, 0, lat, dq);
    @(negedge clk_100MHz);
    ram_a = 27'h20; ram_dq_i = 32'h1234_5678; ram_wen = 1'b0; ram_oen = 1'b1;
    ram_ub = 1'b0; ram_lb = 1'b0; ram_cen = 1'b0;
    @(posedge clk_100MHz); #1;
    @(posedge clk_100MHz); #1;
    chk("mid_wr_busy", {31'd0, busy}, 32'd1);
    @(negedge clk_100MHz);
    rstn = 1'b0; ram_cen = 1'b1; ram_wen = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_ack",  {31'd0, ack},  32'd0);
    chk("arst_dq",   ram_dq_o, 32'd0);
    chk("arst_err",  {31'd0, err},  32'd0);
    @(negedge clk_100MHz);
    rstn = 1'b1;
    @(negedge clk_100MHz); @(negedge clk_100MHz);
    txn(27'h20, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 0, lat, dq);
    chk("arst_rd_lat", lat, RD_LAT);
    chk("arst_no_commit", dq, 32'h0BAD_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
